shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one combinational `shift` instance (ports i_1, shamt, shope, o) between NUM_REQ requesters.
- Arbitration is round-robin; each requester uses a valid/ready handshake.
- Accepted operands are registered. The result is presented on a single response channel, tagged with the requester index, and held under backpressure.
- Sits between ALU-issue clients and the shared shifter, so only one shifter is needed in the 32-bit ALU.

Parameters:
- WIDTH, 32, data width of operand and result.
- SHAMT_WIDTH, $clog2(WIDTH), shift-amount width.
- NUM_REQ, 4, number of requesters (>=2).
- ID_WIDTH, $clog2(NUM_REQ), width of requester index.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; at most one bit high.
- req_i_1  input  NUM_REQ*WIDTH  packed operands; requester k at bits [k*WIDTH +: WIDTH].
- req_shamt  input  NUM_REQ*SHAMT_WIDTH  packed shift amounts.
- req_shope  input  NUM_REQ  per-requester op: 1 = shift left logical, 0 = shift right logical.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  ID_WIDTH  index of requester that owns the response.
- rsp_o  output  WIDTH  shift result.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, rr_ptr=0.
  - Operand registers op_i_1/op_shamt/op_shope = 0, rsp_id=0.
  - Outputs: rsp_valid=0, req_ready=0, rsp_o=0.
  - A pending response is discarded; no handshake completes in the reset cycle.
- FSM states: IDLE, RESP.
- IDLE:
  - Grant g = first k with req_valid[k]=1, searching k = rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - req_ready = one-hot(g), combinational from req_valid and state, same cycle.
  - On any grant at edge N:
    - Capture req_i_1[g], req_shamt[g], req_shope[g] into op regs; rsp_id<=g.
    - rr_ptr <= (g+1) mod NUM_REQ; state <= RESP.
  - No req_valid: req_ready=0, nothing changes.
- RESP:
  - rsp_valid=1. rsp_o = shifter output driven from op regs (combinational from registers, stable while held).
  - rsp_o, rsp_id and rsp_valid stay stable until rsp_ready=1.
  - rsp_valid && rsp_ready at an edge: state <= IDLE.
  - req_ready=0 throughout RESP.
- Latency: request accepted at edge N -> rsp_valid=1 in cycle after N.
- Throughput: 1 result per 2 cycles (base build).
- Arithmetic:
  - shope=1: rsp_o = (op_i_1 << op_shamt) truncated to WIDTH.
  - shope=0: rsp_o = op_i_1 >> op_shamt, zero-fill.
  - shamt=0 returns the operand unchanged.
- Requester rules:
  - Hold req_valid and operands stable until req_ready.
  - Dropping req_valid before grant is allowed; the arbiter ignores it.
- Fairness and wrap-around:
  - rr_ptr wraps from NUM_REQ-1 to 0.
  - With all requesters continuously valid, grants rotate 0,1,2,3,0,...
- Simultaneous events: a request arriving while in RESP waits; it is not lost or pre-latched.

Optional Feature:
- Macro: SHIFT_ARB_PIPE_EN.
- Defined: in RESP, if rsp_ready=1, the arbiter also arbitrates that cycle.
  - On a grant, a new operand set is captured and rsp_id updated at the same edge the response completes; state stays RESP.
  - With no grant, state goes to IDLE.
  - Throughput becomes 1 result per cycle; latency is unchanged.
- Undefined: base behaviour above; req_ready is never high in RESP.

Test Plan:
- Reset: hold rst_n=0 3 cycles with req_valid=4'b1111 -> req_ready=0, rsp_valid=0, rsp_o=0; first grant after release goes to requester 0.
- Single request: req 2 sends i_1=3, shamt=2, shope=1 -> req_ready[2]=1 for one cycle; next cycle rsp_valid=1, rsp_id=2, rsp_o=12. Then req 2 sends i_1=10000, shamt=6, shope=0 -> rsp_o=156.
- Round-robin:
  - All four valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0.
  - Results match the golden model (shope ? i_1*2**shamt : i_1/2**shamt) for i_1=27/shamt=5/left -> 864 and i_1=4/shamt=9/right -> 0.
- Backpressure: rsp_ready=0 for 5 cycles with req 1 waiting -> rsp_o/rsp_id stable, req_ready=0; after rsp_ready=1, req 1 granted the following IDLE cycle.
- Truncation and reset mid-operation:
  - i_1=32'h00FFF000, shamt=22, left -> rsp_o=32'h00000000.
  - Assert rst_n=0 while in RESP -> rsp_valid=0 next cycle; the response is never delivered.
- SHIFT_ARB_PIPE_EN build: two requesters continuously valid, rsp_ready=1 -> rsp_valid stays 1 every cycle with rsp_id alternating 0,1,0,1.

Source files
------------

// File: rtl/shift_arbiter.sv
//------------------------------------------------------------------------------
// Module      : shift_arbiter (with local helper module: shift)
// Description : Round-robin arbiter that shares a single combinational barrel
//               shifter between NUM_REQ requesters. Each requester offers
//               an operand, a shift amount and a direction under a
//               valid/ready handshake. The winner's operands are registered.
//               The shift result is returned on one response channel, tagged
//               with the requester index and held stable under backpressure.
//
// Ports       : clk        - clock, all logic on rising edge
//               rst_n      - synchronous active-low reset
//               req_valid  - [NUM_REQ]             per-requester valid
//               req_ready  - [NUM_REQ]             per-requester accept (one-hot or 0)
//               req_i_1    - [NUM_REQ*WIDTH]       packed operands, req k at [k*WIDTH +: WIDTH]
//               req_shamt  - [NUM_REQ*SHAMT_WIDTH] packed shift amounts
//               req_shope  - [NUM_REQ]             1 = shift left logical, 0 = shift right logical
//               rsp_valid  - response valid
//               rsp_ready  - response consumer ready
//               rsp_id     - [ID_WIDTH] index of the requester owning the response
//               rsp_o      - [WIDTH]    shift result
//
// Config      : SHIFT_ARB_PIPE_EN - when defined, the arbiter also grants in
//               the cycle a response is consumed, so back-to-back results
//               come out at one per cycle. Undefined: one result per two
//               cycles, req_ready never high while a response is pending.
//
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

//------------------------------------------------------------------------------
// shift : combinational logical shifter, left when shope=1, right otherwise.
// Bits shifted past the MSB are dropped; right shifts zero-fill.
//------------------------------------------------------------------------------
module shift #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0]       i_1,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  input  logic                   shope,
  output logic [WIDTH-1:0]       o
);

  assign o = shope ? (i_1 << shamt) : (i_1 >> shamt);

endmodule

//------------------------------------------------------------------------------
// shift_arbiter : top level
//------------------------------------------------------------------------------
module shift_arbiter #(
  parameter int WIDTH       = 32,
  parameter int SHAMT_WIDTH = $clog2(WIDTH),
  parameter int NUM_REQ     = 4,
  parameter int ID_WIDTH    = $clog2(NUM_REQ)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  output logic [NUM_REQ-1:0]             req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]       req_i_1,
  input  logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt,
  input  logic [NUM_REQ-1:0]             req_shope,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [WIDTH-1:0]               rsp_o
);

  //----------------------------------------------------------------------------
  // Types and constants
  //----------------------------------------------------------------------------
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  localparam logic [NUM_REQ-1:0] c_ONEHOT_BASE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  // (base + ofs) mod NUM_REQ for ofs in [0, NUM_REQ); a single conditional
  // subtract suffices, which keeps this valid for non-power-of-two NUM_REQ.
  function automatic logic [ID_WIDTH-1:0] f_wrap_add(
    input logic [ID_WIDTH-1:0] base,
    input int                  ofs
  );
    int s;
    s = int'(base) + ofs;
    if (s >= NUM_REQ) begin
      s = s - NUM_REQ;
    end
    return s[ID_WIDTH-1:0];
  endfunction

  //----------------------------------------------------------------------------
  // Registers
  //----------------------------------------------------------------------------
  state_t                   r_state;
  logic [ID_WIDTH-1:0]      r_rr_ptr;
  logic [WIDTH-1:0]         r_op_i_1;
  logic [SHAMT_WIDTH-1:0]   r_op_shamt;
  logic                     r_op_shope;
  logic [ID_WIDTH-1:0]      r_rsp_id;

  //----------------------------------------------------------------------------
  // Combinational signals
  //----------------------------------------------------------------------------
  state_t                   w_state_nxt;
  logic                     w_arb_en;       // arbitration allowed this cycle
  logic                     w_grant_found;  // some requester is valid
  logic [ID_WIDTH-1:0]      w_grant_idx;    // round-robin winner
  logic                     w_take;         // handshake completes at next edge
  logic [WIDTH-1:0]         w_req_i_1   [NUM_REQ];
  logic [SHAMT_WIDTH-1:0]   w_req_shamt [NUM_REQ];
  logic [WIDTH-1:0]         w_shift_o;

  //----------------------------------------------------------------------------
  // Unpack the flat request buses into per-requester arrays
  //----------------------------------------------------------------------------
  generate
    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
      assign w_req_i_1[k]   = req_i_1[k*WIDTH +: WIDTH];
      assign w_req_shamt[k] = req_shamt[k*SHAMT_WIDTH +: SHAMT_WIDTH];
    end
  endgenerate

  //----------------------------------------------------------------------------
  // Arbitration window. In the pipelined build a consumed response frees the
  // operand registers at the same edge, so a new grant can land there.
  //----------------------------------------------------------------------------
`ifdef SHIFT_ARB_PIPE_EN
  assign w_arb_en = (r_state == ST_IDLE) || ((r_state == ST_RESP) && rsp_ready);
`else
  assign w_arb_en = (r_state == ST_IDLE);
`endif

  //----------------------------------------------------------------------------
  // Round-robin search starting at r_rr_ptr; the first valid requester wins.
  //----------------------------------------------------------------------------
  always_comb begin
    w_grant_found = 1'b0;
    w_grant_idx   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_grant_found && req_valid[f_wrap_add(r_rr_ptr, i)]) begin
        w_grant_found = 1'b1;
        w_grant_idx   = f_wrap_add(r_rr_ptr, i);
      end
    end
  end

  // rst_n gating keeps handshakes from completing while reset is applied,
  // including the first cycle before the state register has been cleared.
  assign w_take = rst_n && w_arb_en && w_grant_found;

  assign req_ready = w_take ? (c_ONEHOT_BASE << w_grant_idx) : '0;

  //----------------------------------------------------------------------------
  // FSM: state register
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  //----------------------------------------------------------------------------
  // FSM: next-state logic
  //----------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_take) begin
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
`ifdef SHIFT_ARB_PIPE_EN
          // Back-to-back: stay in RESP when a new operand set is captured.
          w_state_nxt = w_take ? ST_RESP : ST_IDLE;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  //----------------------------------------------------------------------------
  // Operand capture and round-robin pointer update
  //----------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rr_ptr   <= '0;
      r_op_i_1   <= '0;
      r_op_shamt <= '0;
      r_op_shope <= 1'b0;
      r_rsp_id   <= '0;
    end else if (w_take) begin
      r_op_i_1   <= w_req_i_1[w_grant_idx];
      r_op_shamt <= w_req_shamt[w_grant_idx];
      r_op_shope <= req_shope[w_grant_idx];
      r_rsp_id   <= w_grant_idx;
      // The winner moves to lowest priority for the next round.
      r_rr_ptr   <= f_wrap_add(w_grant_idx, 1);
    end
  end

  //----------------------------------------------------------------------------
  // Shared shifter, fed only from registers so the result is stable while
  // the response is held.
  //----------------------------------------------------------------------------
  shift #(
    .WIDTH       (WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH)
  ) u_shift (
    .i_1   (r_op_i_1),
    .shamt (r_op_shamt),
    .shope (r_op_shope),
    .o     (w_shift_o)
  );

  //----------------------------------------------------------------------------
  // Response channel
  //----------------------------------------------------------------------------
  assign rsp_valid = rst_n && (r_state == ST_RESP);
  assign rsp_id    = r_rsp_id;
  assign rsp_o     = w_shift_o;

endmodule

`default_nettype wire

// File: tb/tb_shift_arbiter.sv
//------------------------------------------------------------------------------
// Module      : tb_shift_arbiter
// Description : Directed self-checking bench for shift_arbiter. Inputs are
//               driven 1 time unit after the rising edge, outputs are sampled
//               2 units after it. Expected values are hand-computed.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_shift_arbiter;

  localparam int WIDTH       = 32;
  localparam int SHAMT_WIDTH = 5;
  localparam int NUM_REQ     = 4;
  localparam int ID_WIDTH    = 2;

  logic                           clk;
  logic                           rst_n;
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_ready;
  logic [NUM_REQ*WIDTH-1:0]       req_i_1;
  logic [NUM_REQ*SHAMT_WIDTH-1:0] req_shamt;
  logic [NUM_REQ-1:0]             req_shope;
  logic                           rsp_valid;
  logic                           rsp_ready;
  logic [ID_WIDTH-1:0]            rsp_id;
  logic [WIDTH-1:0]               rsp_o;

  int checks = 0;
  int errors = 0;

  shift_arbiter #(
    .WIDTH       (WIDTH),
    .SHAMT_WIDTH (SHAMT_WIDTH),
    .NUM_REQ     (NUM_REQ),
    .ID_WIDTH    (ID_WIDTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_i_1   (req_i_1),
    .req_shamt (req_shamt),
    .req_shope (req_shope),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_o     (rsp_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance to 1 unit after the next rising edge (input drive point).
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Settle combinational outputs before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic set_req(input int k, input logic [31:0] a, input logic [4:0] sh, input logic op);
    req_i_1[k*WIDTH +: WIDTH]             = a;
    req_shamt[k*SHAMT_WIDTH +: SHAMT_WIDTH] = sh;
    req_shope[k]                          = op;
  endtask

  // One isolated request from requester k: grant, then one response cycle.
  task automatic single(input string tag, input int k, input logic [31:0] a,
                        input logic [4:0] sh, input logic op, input logic [31:0] exp);
    logic [3:0] oh;
    oh = 4'b0001 << k;
    set_req(k, a, sh, op);
    req_valid = oh;
    settle();
    check({tag, "_ready"}, 32'(req_ready), 32'(oh));
    step();
    req_valid = '0;
    settle();
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    check({tag, "_id"},    32'(rsp_id),    32'(k));
    check({tag, "_o"},     rsp_o,          exp);
    check({tag, "_rdy0"},  32'(req_ready), 32'd0);
    step();
    settle();
    check({tag, "_done"},  32'(rsp_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    req_i_1   = '0;
    req_shamt = '0;
    req_shope = '0;
    set_req(0, 32'd5, 5'd1, 1'b1);   // 5 << 1 = 10

    // ---------------- reset held 3 cycles with all requesters valid
    for (int i = 0; i < 3; i++) begin
      step();
      settle();
      check("rst_ready", 32'(req_ready), 32'd0);
      check("rst_valid", 32'(rsp_valid), 32'd0);
      check("rst_o",     rsp_o,          32'd0);
    end
    rst_n = 1'b1;
    settle();
    check("first_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = '0;
    settle();
    check("first_id", 32'(rsp_id), 32'd0);
    check("first_o",  rsp_o,        32'd10);
    step();                          // back to IDLE, rr_ptr = 1

    // ---------------- single requests from requester 2
    single("sl", 2, 32'd3,     5'd2, 1'b1, 32'd12);
    single("sr", 2, 32'd10000, 5'd6, 1'b0, 32'd156);
    // rr_ptr is now 3

`ifdef SHIFT_ARB_PIPE_EN
    // ---------------- back-to-back with two requesters
    set_req(0, 32'd1, 5'd4, 1'b1);   // 16
    set_req(1, 32'd64, 5'd3, 1'b0);  // 8
    rsp_ready = 1'b1;
    req_valid = 4'b0011;
    step();                          // first grant (search 3,0 -> 0)
    begin
      int exp_id [4] = '{0, 1, 0, 1};
      for (int i = 0; i < 4; i++) begin
        settle();
        check("pipe_valid", 32'(rsp_valid), 32'd1);
        check("pipe_id",    32'(rsp_id),    32'(exp_id[i]));
        check("pipe_o",     rsp_o,          (exp_id[i] == 0) ? 32'd16 : 32'd8);
        step();
      end
    end
    req_valid = '0;
    step();
    step();
`else
    // ---------------- round robin with all four continuously valid
    set_req(0, 32'd27,        5'd5,  1'b1);  // 864
    set_req(1, 32'd4,         5'd9,  1'b0);  // 0
    set_req(2, 32'h00FFF000,  5'd22, 1'b1);  // truncated to 0
    set_req(3, 32'h80000001,  5'd31, 1'b0);  // 1
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    begin
      int          exp_id [6] = '{3, 0, 1, 2, 3, 0};
      logic [31:0] exp_o  [4] = '{32'd864, 32'd0, 32'd0, 32'd1};
      for (int i = 0; i < 6; i++) begin
        settle();
        check("rr_ready", 32'(req_ready), 32'(4'b0001 << exp_id[i]));
        step();
        settle();
        check("rr_id", 32'(rsp_id), 32'(exp_id[i]));
        check("rr_o",  rsp_o,        exp_o[exp_id[i]]);
        step();
      end
    end
    req_valid = '0;
    // rr_ptr is now 1

    // ---------------- backpressure with requester 1 waiting
    req_valid = 4'b0001;
    settle();
    check("bp_grant", 32'(req_ready), 32'b0001);
    step();
    req_valid = 4'b0010;
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      settle();
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_id",    32'(rsp_id),    32'd0);
      check("bp_o",     rsp_o,          32'd864);
      check("bp_ready", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    settle();
    check("bp_release_ready", 32'(req_ready), 32'd0);
    step();                          // response consumed -> IDLE
    settle();
    check("bp_idle_valid", 32'(rsp_valid), 32'd0);
    check("bp_req1_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    settle();
    check("bp_req1_id", 32'(rsp_id), 32'd1);
    step();
`endif

    // ---------------- truncation, then reset while the response is pending
    set_req(2, 32'h00FFF000, 5'd22, 1'b1);
    req_valid = 4'b0100;
    rsp_ready = 1'b0;
    step();                          // grant regardless of rr_ptr (only req 2)
    req_valid = '0;
    settle();
    check("trunc_valid", 32'(rsp_valid), 32'd1);
    check("trunc_id",    32'(rsp_id),    32'd2);
    check("trunc_o",     rsp_o,          32'd0);
    set_req(1, 32'd7, 5'd3, 1'b1);   // 56, used after reset
    req_valid = 4'b0100;
    rst_n = 1'b0;
    step();
    settle();
    check("mrst_valid", 32'(rsp_valid), 32'd0);
    check("mrst_ready", 32'(req_ready), 32'd0);
    rst_n     = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    settle();
    check("mrst_after_valid", 32'(rsp_valid), 32'd0);
    check("mrst_after_o",     rsp_o,          32'd0);
    step();
    settle();
    check("mrst_never_valid", 32'(rsp_valid), 32'd0);
    // Pointer is back at 0: of requesters 1 and 2, 1 wins.
    req_valid = 4'b0110;
    settle();
    check("mrst_ptr_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid = '0;
    settle();
    check("mrst_ptr_o", rsp_o, 32'd56);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
